// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to writeback, or runs one data-memory access per
// instruction with a req/ack handshake, store lane steering and load extension.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        mis_q, mis_d;
  logic        wbv_q, wbv_d;
  logic        wbrw_q, wbrw_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbdata_q, wbdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;

  logic        is_mem;
  logic        mis_acc;
  logic [1:0]  off;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [15:0] lane;
  logic [31:0] ld_data;
  logic        stall_c;

  // Access decode and store lane steering for the instruction currently in EX
  always_comb begin
    is_mem = ex_mem_read | ex_mem_write;
    off    = ex_alu_result[1:0];
    case (ex_funct3[1:0])
      2'b00: begin
        mis_acc = 1'b0;
        st_strb = 4'b0001 << off;
        st_data = {4{ex_rs2_data[7:0]}};
      end
      2'b01: begin
        mis_acc = off[0];
        st_strb = 4'b0011 << off;
        st_data = {2{ex_rs2_data[15:0]}};
      end
      default: begin
        mis_acc = (off != 2'b00);
        st_strb = 4'b1111;
        st_data = ex_rs2_data;
      end
    endcase
  end

  // Load lane select from the captured byte offset
  always_comb begin
    lane = 16'(dmem_rdata >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'h0, lane[7:0]};
      3'b101:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    mis_d    = 1'b0;
    wbv_d    = 1'b0;
    wbrw_d   = wbrw_q;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    stall_c  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wbv_d    = 1'b1;
            wbdata_d = ex_alu_result;
            wbrd_d   = ex_rd;
            wbrw_d   = ex_reg_write;
          end else if (mis_acc) begin
            wbv_d  = 1'b1;
            wbrd_d = ex_rd;
            wbrw_d = 1'b0;
            mis_d  = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = StWait;
            req_d   = 1'b1;
            addr_d  = {ex_alu_result[31:2], 2'b00};
            // A write flag wins over a read flag
            we_d    = ex_mem_write;
            wstrb_d = ex_mem_write ? st_strb : 4'b0000;
            wdata_d = ex_mem_write ? st_data : 32'h0;
            f3_d    = ex_funct3;
            off_d   = off;
            rd_d    = ex_rd;
            rw_d    = ex_reg_write & ~ex_mem_write;
          end
        end
      end
      StWait: begin
        if (dmem_ack) begin
          state_d  = StIdle;
          req_d    = 1'b0;
          we_d     = 1'b0;
          wstrb_d  = 4'b0000;
          wbv_d    = 1'b1;
          wbrd_d   = rd_q;
          wbrw_d   = rw_q;
          wbdata_d = ld_data;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'b0000;
      mis_q    <= 1'b0;
      wbv_q    <= 1'b0;
      wbrw_q   <= 1'b0;
      wbrd_q   <= 5'd0;
      wbdata_q <= 32'h0;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      rd_q     <= 5'd0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      mis_q    <= mis_d;
      wbv_q    <= wbv_d;
      wbrw_q   <= wbrw_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign stall        = stall_c & ~rst;
  assign misalign     = mis_q;
  assign wb_valid     = wbv_q;
  assign wb_reg_write = wbrw_q;
  assign wb_rd        = wbrd_q;
  assign wb_data      = wbdata_q;

endmodule
